// File: rtl/vga_fb_writer_if.sv
// vga_fb_writer_if: command handshake and video-RAM write port of the
// frame-buffer writer, bundled so both sides connect through one port.
interface vga_fb_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [7:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [15:0] cmd_data;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    // Command source / RAM-side observer
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_data,
        input  cmd_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );

    // Frame-buffer writer
    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_data,
        output cmd_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );
endinterface

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: write-side controller for the dual-port video RAM.
// Accepts WRITE / FILL / CLEAR commands, clips the region to the frame,
// and issues one row-major RAM write per clock. All outputs registered.
module vga_fb_writer #(
    parameter int unsigned COLS = 160,
    parameter int unsigned ROWS = 120
) (
    input  logic           clk,
    input  logic           reset,
    vga_fb_writer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0]  OP_WRITE = 2'b00;
    localparam logic [1:0]  OP_FILL  = 2'b01;
    localparam logic [1:0]  OP_CLEAR = 2'b10;

    localparam logic [15:0] C_COLS   = 16'(COLS);
    localparam logic [15:0] C_ROWS   = 16'(ROWS);
    localparam logic [14:0] C_STRIDE = 15'(COLS);

    // FSM state
    state_t      r_state, w_state_n;

    // Latched command fields
    logic [1:0]  r_op,   w_op_n;
    logic [7:0]  r_x,    w_x_n;
    logic [6:0]  r_y,    w_y_n;
    logic [7:0]  r_w,    w_w_n;
    logic [6:0]  r_h,    w_h_n;
    logic [15:0] r_data, w_data_n;

    // Region walk
    logic [15:0] r_col,      w_col_n;
    logic [15:0] r_row,      w_row_n;
    logic [15:0] r_wc,       w_wc_n;
    logic [15:0] r_hc,       w_hc_n;
    logic [14:0] r_row_base, w_row_base_n;

    // Registered outputs
    logic        r_ready, w_ready_n;
    logic        r_busy,  w_busy_n;
    logic        r_done,  w_done_n;
    logic        r_err,   w_err_n;
    logic        r_we,    w_we_n;
    logic [14:0] r_addr,  w_addr_n;
    logic [15:0] r_wdata, w_wdata_n;

    // Region resolution (consumed only in SETUP)
    logic [15:0] w_reg_x, w_reg_y, w_reg_w, w_reg_h;
    logic [15:0] w_span_x, w_span_y;
    logic [15:0] w_clip_w, w_clip_h;
    logic [14:0] w_row_base;
    logic        w_reject;
    logic        w_handshake;
    logic        w_last_col;
    logic        w_last_row;

    assign w_handshake = bus.cmd_valid & r_ready;
    assign w_last_col  = (r_col == r_wc - 16'd1);
    assign w_last_row  = (r_row == r_hc - 16'd1);

    // Resolve the latched command into a clipped region and its base address
    always_comb begin
        w_reg_x  = {8'd0, r_x};
        w_reg_y  = {9'd0, r_y};
        w_reg_w  = {8'd0, r_w};
        w_reg_h  = {9'd0, r_h};
        w_reject = 1'b0;
        case (r_op)
            OP_WRITE: begin
                w_reg_w = 16'd1;
                w_reg_h = 16'd1;
            end
            OP_FILL: begin
                w_reject = 1'b0;
            end
            OP_CLEAR: begin
                w_reg_x = '0;
                w_reg_y = '0;
                w_reg_w = C_COLS;
                w_reg_h = C_ROWS;
            end
            default: begin
                w_reject = 1'b1;
            end
        endcase
        if ((w_reg_x >= C_COLS) || (w_reg_y >= C_ROWS)) begin
            w_reject = 1'b1;
        end
        w_span_x   = C_COLS - w_reg_x;
        w_span_y   = C_ROWS - w_reg_y;
        w_clip_w   = (w_reg_w < w_span_x) ? w_reg_w : w_span_x;
        w_clip_h   = (w_reg_h < w_span_y) ? w_reg_h : w_span_y;
        w_row_base = 15'(w_reg_y * C_COLS + w_reg_x);
    end

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so that every output can be a plain register.
    always_comb begin
        w_state_n    = r_state;
        w_op_n       = r_op;
        w_x_n        = r_x;
        w_y_n        = r_y;
        w_w_n        = r_w;
        w_h_n        = r_h;
        w_data_n     = r_data;
        w_col_n      = r_col;
        w_row_n      = r_row;
        w_wc_n       = r_wc;
        w_hc_n       = r_hc;
        w_row_base_n = r_row_base;
        w_ready_n    = 1'b0;
        w_busy_n     = 1'b1;
        w_done_n     = 1'b0;
        w_err_n      = 1'b0;
        w_we_n       = 1'b0;
        w_addr_n     = r_addr;
        w_wdata_n    = r_wdata;

        case (r_state)
            S_IDLE: begin
                w_ready_n = 1'b1;
                w_busy_n  = 1'b0;
                if (w_handshake) begin
                    w_state_n = S_SETUP;
                    w_op_n    = bus.cmd_op;
                    w_x_n     = bus.cmd_x;
                    w_y_n     = bus.cmd_y;
                    w_w_n     = bus.cmd_w;
                    w_h_n     = bus.cmd_h;
                    w_data_n  = bus.cmd_data;
                    w_ready_n = 1'b0;
                    w_busy_n  = 1'b1;
                end
            end

            S_SETUP: begin
                w_col_n      = '0;
                w_row_n      = '0;
                w_wc_n       = w_clip_w;
                w_hc_n       = w_clip_h;
                w_row_base_n = w_row_base;
                if (w_reject) begin
                    w_state_n = S_DONE;
                    w_done_n  = 1'b1;
                    w_err_n   = 1'b1;
                end else if ((w_clip_w == 16'd0) || (w_clip_h == 16'd0)) begin
                    w_state_n = S_DONE;
                    w_done_n  = 1'b1;
                end else begin
                    // First write of the region is issued on entry to WRITE
                    w_state_n = S_WRITE;
                    w_we_n    = 1'b1;
                    w_addr_n  = w_row_base;
                    w_wdata_n = r_data;
                end
            end

            S_WRITE: begin
                if (w_last_col && w_last_row) begin
                    w_state_n = S_DONE;
                    w_done_n  = 1'b1;
                end else if (w_last_col) begin
                    w_col_n      = '0;
                    w_row_n      = r_row + 16'd1;
                    w_row_base_n = r_row_base + C_STRIDE;
                    w_we_n       = 1'b1;
                    w_addr_n     = r_row_base + C_STRIDE;
                    w_wdata_n    = r_data;
                end else begin
                    w_col_n   = r_col + 16'd1;
                    w_we_n    = 1'b1;
                    w_addr_n  = r_row_base + 15'(r_col + 16'd1);
                    w_wdata_n = r_data;
                end
            end

            S_DONE: begin
                w_state_n = S_IDLE;
                w_ready_n = 1'b1;
                w_busy_n  = 1'b0;
            end

            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_data     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_wc       <= '0;
            r_hc       <= '0;
            r_row_base <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_op       <= w_op_n;
            r_x        <= w_x_n;
            r_y        <= w_y_n;
            r_w        <= w_w_n;
            r_h        <= w_h_n;
            r_data     <= w_data_n;
            r_col      <= w_col_n;
            r_row      <= w_row_n;
            r_wc       <= w_wc_n;
            r_hc       <= w_hc_n;
            r_row_base <= w_row_base_n;
            r_ready    <= w_ready_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_err      <= w_err_n;
            r_we       <= w_we_n;
            r_addr     <= w_addr_n;
            r_wdata    <= w_wdata_n;
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_vga_fb_writer.sv
// tb_vga_fb_writer: self-checking bench for vga_fb_writer. Directed table,
// reset/abort sequences and random commands against a region model.
module tb_vga_fb_writer;

    localparam int COLS = 160;
    localparam int ROWS = 120;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;

    vga_fb_writer_if bus ();

    vga_fb_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Reference model: list of addresses the command should write, in order
    int exp_q[$];
    int exp_rej;

    task automatic build_model(input int op, input int x, input int y,
                               input int w, input int h);
        int rx, ry, rw, rh;
        exp_q.delete();
        exp_rej = 0;
        if (op == 3) begin
            exp_rej = 1;
            return;
        end
        if (op == 2) begin
            rx = 0; ry = 0; rw = COLS; rh = ROWS;
        end else begin
            rx = x; ry = y;
            rw = (op == 0) ? 1 : w;
            rh = (op == 0) ? 1 : h;
            if (rx >= COLS || ry >= ROWS) begin
                exp_rej = 1;
                return;
            end
        end
        if (rw > COLS - rx) rw = COLS - rx;
        if (rh > ROWS - ry) rh = ROWS - ry;
        for (int r = 0; r < rh; r++)
            for (int c = 0; c < rw; c++)
                exp_q.push_back((ry + r) * COLS + rx + c);
    endtask

    task automatic wait_ready();
        int budget;
        budget = 60;
        while (bus.cmd_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (bus.cmd_ready !== 1'b1) chk("ready_wait", int'(bus.cmd_ready), 1);
    endtask

    // Issue one command and check its whole execution against the model
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] x,
                           input logic [6:0] y, input logic [7:0] w,
                           input logic [6:0] h, input logic [15:0] d,
                           output int n_wr, output int first_a,
                           output int last_a, output int got_err,
                           output int done_off);
        int  c, limit, bad_i, bad_a, bad_c;
        bit  seq_ok, busy_ok, rdy_ok, stray_err;
        build_model(int'(op), int'(x), int'(y), int'(w), int'(h));
        wait_ready();
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_x     = 8'($urandom);
        bus.cmd_y     = 7'($urandom);
        bus.cmd_w     = 8'($urandom);
        bus.cmd_h     = 7'($urandom);
        bus.cmd_data  = 16'($urandom);
        n_wr = 0; first_a = -1; last_a = -1; got_err = 0; done_off = -1;
        seq_ok = 1; busy_ok = 1; rdy_ok = 1; stray_err = 0;
        bad_i = 0; bad_a = 0; bad_c = 0;
        limit = exp_q.size() + 8;
        c = 1;
        forever begin
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (bus.cmd_ready !== 1'b0) rdy_ok = 0;
            if (bus.mem_we === 1'b1) begin
                if (seq_ok && (n_wr >= exp_q.size() ||
                               int'(bus.mem_addr) != exp_q[n_wr] ||
                               bus.mem_wdata != d || c != n_wr + 2)) begin
                    seq_ok = 0;
                    bad_i = n_wr; bad_a = int'(bus.mem_addr); bad_c = c;
                end
                if (n_wr == 0) first_a = int'(bus.mem_addr);
                last_a = int'(bus.mem_addr);
                n_wr++;
            end
            if (bus.done === 1'b1) begin
                done_off = c;
                got_err  = int'(bus.err);
            end else if (bus.err === 1'b1) begin
                stray_err = 1;
            end
            if (done_off >= 0 || c >= limit) break;
            @(negedge clk);
            c++;
        end
        chk("n_writes", n_wr, exp_q.size());
        if (!seq_ok)
            chk($sformatf("write_seq idx=%0d addr=%0d cyc=%0d", bad_i, bad_a, bad_c),
                int'(seq_ok), 1);
        else
            chk("write_seq", int'(seq_ok), 1);
        chk("done_cycle", done_off, exp_q.size() + 2);
        chk("err", got_err, exp_rej);
        chk("err_without_done", int'(stray_err), 0);
        chk("busy_held", int'(busy_ok), 1);
        chk("ready_low", int'(rdy_ok), 1);
        if (n_wr > 0) begin
            chk("addr_hold", int'(bus.mem_addr), last_a);
            chk("data_hold", int'(bus.mem_wdata), int'(d));
        end
        @(negedge clk);
        chk("ready_back", int'(bus.cmd_ready), 1);
        chk("done_drop", int'(bus.done), 0);
        chk("busy_drop", int'(bus.busy), 0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [7:0]  w;
        logic [6:0]  h;
        logic [15:0] d;
        int          n;
        int          first;
        int          last;
        int          err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int n_wr, first_a, last_a, got_err, done_off, nw, k;
        bit stray;
        logic [1:0] rop;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;

        tbl[0]  = '{2'd0, 8'd5,   7'd2,   8'd0,   7'd0,   16'hBEEF, 1,     325,   325,   0};
        tbl[1]  = '{2'd1, 8'd158, 7'd118, 8'd4,   7'd4,   16'h00FF, 4,     19038, 19199, 0};
        tbl[2]  = '{2'd3, 8'd1,   7'd1,   8'd1,   7'd1,   16'h1111, 0,     -1,    -1,    1};
        tbl[3]  = '{2'd1, 8'd160, 7'd0,   8'd4,   7'd4,   16'h2222, 0,     -1,    -1,    1};
        tbl[4]  = '{2'd1, 8'd10,  7'd10,  8'd0,   7'd5,   16'h3333, 0,     -1,    -1,    0};
        tbl[5]  = '{2'd1, 8'd10,  7'd10,  8'd5,   7'd0,   16'h4444, 0,     -1,    -1,    0};
        tbl[6]  = '{2'd0, 8'd0,   7'd120, 8'd1,   7'd1,   16'h5555, 0,     -1,    -1,    1};
        tbl[7]  = '{2'd1, 8'd0,   7'd5,   8'd200, 7'd1,   16'h5A5A, 160,   800,   959,   0};
        tbl[8]  = '{2'd1, 8'd159, 7'd119, 8'd1,   7'd1,   16'hFFFF, 1,     19199, 19199, 0};
        tbl[9]  = '{2'd1, 8'd10,  7'd3,   8'd3,   7'd2,   16'h1234, 6,     490,   652,   0};
        tbl[10] = '{2'd0, 8'd255, 7'd127, 8'd1,   7'd1,   16'h6666, 0,     -1,    -1,    1};
        tbl[11] = '{2'd2, 8'd50,  7'd50,  8'd1,   7'd1,   16'h0000, 19200, 0,     19199, 0};
        tbl[12] = '{2'd1, 8'd150, 7'd100, 8'd255, 7'd127, 16'h0F0F, 200,   16150, 19199, 0};
        tbl[13] = '{2'd0, 8'd3,   7'd0,   8'd0,   7'd0,   16'h8001, 1,     3,     3,     0};
        tbl[14] = '{2'd1, 8'd0,   7'd119, 8'd3,   7'd7,   16'h7E7E, 3,     19040, 19042, 0};

        // Reset held three cycles with a pending command
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_x     = 8'd1;
        bus.cmd_y     = 7'd1;
        bus.cmd_w     = 8'd1;
        bus.cmd_h     = 7'd1;
        bus.cmd_data  = 16'hDEAD;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(bus.cmd_ready), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_err",   int'(bus.err), 0);
        chk("rst_we",    int'(bus.mem_we), 0);
        chk("rst_addr",  int'(bus.mem_addr), 0);
        chk("rst_wdata", int'(bus.mem_wdata), 0);
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_release", int'(bus.cmd_ready), 1);
        chk("busy_after_release",  int'(bus.busy), 0);
        chk("we_after_release",    int'(bus.mem_we), 0);

        // Directed table
        for (int unsigned i = 0; i < 15; i++) begin
            run_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].d,
                    n_wr, first_a, last_a, got_err, done_off);
            chk($sformatf("tbl%0d_count", i), n_wr, tbl[i].n);
            chk($sformatf("tbl%0d_first", i), first_a, tbl[i].first);
            chk($sformatf("tbl%0d_last", i), last_a, tbl[i].last);
            chk($sformatf("tbl%0d_err", i), got_err, tbl[i].err);
            chk($sformatf("tbl%0d_done", i), done_off, tbl[i].n + 2);
        end

        // Abort a CLEAR after its tenth write
        wait_ready();
        bus.cmd_op    = 2'd2;
        bus.cmd_data  = 16'hC0DE;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        nw = 0;
        k  = 0;
        forever begin
            if (bus.mem_we === 1'b1) nw++;
            if (nw >= 10 || k >= 40) break;
            @(negedge clk);
            k++;
        end
        chk("abort_writes_seen", nw, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_we",    int'(bus.mem_we), 0);
        chk("abort_done",  int'(bus.done), 0);
        chk("abort_busy",  int'(bus.busy), 0);
        chk("abort_ready", int'(bus.cmd_ready), 0);
        reset = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.mem_we === 1'b1) stray = 1;
        end
        chk("abort_no_done", int'(stray), 0);
        run_cmd(2'd0, 8'd7, 7'd1, 8'd9, 7'd9, 16'h1357,
                n_wr, first_a, last_a, got_err, done_off);
        chk("post_abort_addr", first_a, 167);
        chk("post_abort_count", n_wr, 1);

        // Random commands against the model
        for (int unsigned i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'd2) rop = 2'd1;
            run_cmd(rop,
                    ($urandom_range(0, 1) == 1) ? 8'($urandom_range(140, 175))
                                                : 8'($urandom_range(0, 159)),
                    ($urandom_range(0, 1) == 1) ? 7'($urandom_range(100, 127))
                                                : 7'($urandom_range(0, 119)),
                    8'($urandom_range(0, 12)),
                    7'($urandom_range(0, 6)),
                    16'($urandom),
                    n_wr, first_a, last_a, got_err, done_off);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
